// File: rtl/sdram_port_arbiter.sv
// Arbitrates the shared SDRAM command scheduler between AHB ports and auto-refresh.
// Round-robin with bounded write-buffer-full priority; only CTRL_PORT is served outside Normal mode.
module sdram_port_arbiter #(
    parameter int PORTS      = 2,
    parameter int CTRL_PORT  = 0,
    parameter int MAX_URGENT = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             mode_normal_i,
    input  logic [PORTS-1:0] rdreq_i,
    input  logic [PORTS-1:0] wrreq_i,
    input  logic [PORTS-1:0] wbr_i,
    input  logic             refresh_req_i,
    input  logic             done_i,
    output logic [PORTS-1:0] grant_o,
    output logic             grant_wr_o,
    output logic             refresh_gnt_o,
    output logic             busy_o
);

    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        REFRESH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [PORTS-1:0] grant_q, grant_d;
    logic             grant_wr_q, grant_wr_d;
    logic             refresh_gnt_q, refresh_gnt_d;
    logic             busy_q, busy_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [3:0]       urgent_cnt_q, urgent_cnt_d;

    logic [PORTS-1:0] any_req_s, urgent_s;
    logic             urg_found_s, all_found_s, other_nonurg_s;
    logic [PW-1:0]    urg_idx_s, all_idx_s;

    // First requester found scanning ptr+1, ptr+2, ... modulo PORTS; result is {found, index}.
    function automatic logic [PW:0] rr_pick(input logic [PORTS-1:0] req, input logic [PW-1:0] ptr);
        logic          found;
        logic [PW-1:0] idx;
        int            k;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= PORTS; i++) begin
            k = (int'(ptr) + i) % PORTS;
            if (!found && req[k]) begin
                found = 1'b1;
                idx   = PW'(k);
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // Next-state, grant selection and fairness bookkeeping.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_wr_d    = grant_wr_q;
        refresh_gnt_d = refresh_gnt_q;
        rr_ptr_d      = rr_ptr_q;
        urgent_cnt_d  = urgent_cnt_q;

        any_req_s      = rdreq_i | wrreq_i;
        urgent_s       = wbr_i & wrreq_i;
        other_nonurg_s = |(any_req_s & ~urgent_s);
        {urg_found_s, urg_idx_s} = rr_pick(urgent_s, rr_ptr_q);
        {all_found_s, all_idx_s} = rr_pick(any_req_s, rr_ptr_q);

        case (state_q)
            IDLE: begin
                if (refresh_req_i && mode_normal_i) begin
                    state_d       = REFRESH;
                    refresh_gnt_d = 1'b1;
                end else if (!mode_normal_i) begin
                    if (any_req_s[CTRL_PORT]) begin
                        state_d      = GRANT;
                        grant_d      = PORTS'(1'b1) << CTRL_PORT;
                        grant_wr_d   = wrreq_i[CTRL_PORT];
                        rr_ptr_d     = PW'(CTRL_PORT);
                        urgent_cnt_d = 4'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (urg_found_s && (urgent_cnt_q < 4'(MAX_URGENT))) begin
                    state_d    = GRANT;
                    grant_d    = PORTS'(1'b1) << urg_idx_s;
                    grant_wr_d = 1'b1;
                    rr_ptr_d   = urg_idx_s;
                    // Count only grants that actually make a non-urgent requester wait.
                    if (other_nonurg_s) begin
                        urgent_cnt_d = urgent_cnt_q + 4'd1;
                    end else begin
                        urgent_cnt_d = 4'd0;
                    end
                end else if (all_found_s) begin
                    state_d      = GRANT;
                    grant_d      = PORTS'(1'b1) << all_idx_s;
                    grant_wr_d   = wbr_i[all_idx_s] ? 1'b1 : !rdreq_i[all_idx_s];
                    rr_ptr_d     = all_idx_s;
                    urgent_cnt_d = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (done_i) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    grant_wr_d = 1'b0;
                end else begin
                    state_d = GRANT;
                end
            end
            REFRESH: begin
                if (done_i) begin
                    state_d       = IDLE;
                    refresh_gnt_d = 1'b0;
                end else begin
                    state_d = REFRESH;
                end
            end
            default: begin
                state_d       = IDLE;
                grant_d       = '0;
                grant_wr_d    = 1'b0;
                refresh_gnt_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_wr_q    <= 1'b0;
            refresh_gnt_q <= 1'b0;
            busy_q        <= 1'b0;
            rr_ptr_q      <= PW'(PORTS - 1);
            urgent_cnt_q  <= 4'd0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_wr_q    <= grant_wr_d;
            refresh_gnt_q <= refresh_gnt_d;
            busy_q        <= busy_d;
            rr_ptr_q      <= rr_ptr_d;
            urgent_cnt_q  <= urgent_cnt_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_wr_o    = grant_wr_q;
    assign refresh_gnt_o = refresh_gnt_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter (PORTS=2): vector table plus hand-written timing sequences.
module tb_sdram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic [1:0] rd, wr, wbr, grant;
    logic       refresh, done, grant_wr, ref_gnt, busy;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic       mode;
        logic [1:0] rd;
        logic [1:0] wr;
        logic [1:0] wbr;
        logic       rf;
        logic [1:0] g;
        logic       gwr;
        logic       gref;
    } vec_t;

    vec_t vecs[12];

    sdram_port_arbiter #(.PORTS(2), .CTRL_PORT(0), .MAX_URGENT(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .mode_normal_i(mode), .rdreq_i(rd), .wrreq_i(wr),
        .wbr_i(wbr), .refresh_req_i(refresh), .done_i(done), .grant_o(grant),
        .grant_wr_o(grant_wr), .refresh_gnt_o(ref_gnt), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [1:0] g, input logic gwr, input logic gref);
        chk({nm, "_grant"}, 32'(grant), 32'(g));
        chk({nm, "_wr"}, 32'(grant_wr), 32'(gwr));
        chk({nm, "_ref"}, 32'(ref_gnt), 32'(gref));
        chk({nm, "_busy"}, 32'(busy), 32'((|g) | gref));
        chk({nm, "_excl"}, 32'((32'($countones(grant)) + 32'(ref_gnt)) <= 32'd1), 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        mode = 1'b1; rd = 2'b00; wr = 2'b00; wbr = 2'b00; refresh = 1'b0; done = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_in();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic finish_op(input string nm);
        done = 1'b1;
        step();
        done = 1'b0;
        chk_out(nm, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        //               mode  rd     wr     wbr    rf    g      gwr   gref
        vecs[0]  = '{1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 2'b01, 2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 2'b01, 2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 2'b11, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 2'b11, 2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 2'b00, 2'b10, 2'b10, 1'b0, 2'b10, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 2'b00, 2'b10, 2'b00, 1'b0, 2'b10, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 2'b01, 2'b00, 2'b10, 1'b0, 2'b01, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};

        do_reset();
        chk_out("reset", 2'b00, 1'b0, 1'b0);

        // Table: one decision per vector from IDLE, then completion back to IDLE.
        for (int i = 0; i < 12; i++) begin
            mode = vecs[i].mode; rd = vecs[i].rd; wr = vecs[i].wr;
            wbr = vecs[i].wbr; refresh = vecs[i].rf;
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].g, vecs[i].gwr, vecs[i].gref);
            clear_in();
            finish_op($sformatf("vec%0d_done", i));
        end

        // Alternation and done-to-grant latency.
        do_reset();
        rd = 2'b11;
        step(); chk_out("alt_g0", 2'b01, 1'b0, 1'b0);
        step(); chk_out("alt_hold", 2'b01, 1'b0, 1'b0);
        finish_op("alt_idle0");
        step(); chk_out("alt_g1", 2'b10, 1'b0, 1'b0);
        finish_op("alt_idle1");
        step(); chk_out("alt_g2", 2'b01, 1'b0, 1'b0);

        // Init mode: only the control port, then port 1 once Normal.
        do_reset();
        mode = 1'b0; wr = 2'b11;
        for (int i = 0; i < 5; i++) begin
            step(); chk_out($sformatf("init%0d", i), 2'b01, 1'b1, 1'b0);
            finish_op($sformatf("init%0d_done", i));
        end
        mode = 1'b1;
        step(); chk_out("init_normal", 2'b10, 1'b1, 1'b0);

        // Refresh arriving mid-grant wins the next decision.
        do_reset();
        rd = 2'b10;
        step(); chk_out("rf_p1", 2'b10, 1'b0, 1'b0);
        rd = 2'b01; refresh = 1'b1;
        step(); chk_out("rf_p1_hold", 2'b10, 1'b0, 1'b0);
        finish_op("rf_idle0");
        step(); chk_out("rf_gnt", 2'b00, 1'b0, 1'b1);
        step(); chk_out("rf_gnt_hold", 2'b00, 1'b0, 1'b1);
        refresh = 1'b0;
        finish_op("rf_idle1");
        step(); chk_out("rf_p0", 2'b01, 1'b0, 1'b0);

        // Urgent-write starvation bound.
        do_reset();
        wr = 2'b10; wbr = 2'b10; rd = 2'b01;
        for (int i = 0; i < 10; i++) begin
            step();
            if ((i % 5) < 4) begin
                chk_out($sformatf("urg%0d", i), 2'b10, 1'b1, 1'b0);
            end else begin
                chk_out($sformatf("urg%0d", i), 2'b01, 1'b0, 1'b0);
            end
            finish_op($sformatf("urg%0d_done", i));
        end

        // Asynchronous reset in the middle of a grant.
        do_reset();
        rd = 2'b01;
        step(); chk_out("ar_p0", 2'b01, 1'b0, 1'b0);
        rd = 2'b11;
        #2 rst_n = 1'b0;
        #1 chk_out("ar_async", 2'b00, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        step(); chk_out("ar_first", 2'b01, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
